// File: rtl/pack_2_32_pkg.sv
// pack_2_32_pkg -- shared constants, types and helpers for the 2-bit to
// 32-bit field packer.
//   FIELD_W : width of one input field
//   WORD_W  : width of one packed output word
//   FIELDS  : fields per word (field k lives in bits [2k+1:2k])
package pack_2_32_pkg;

  localparam int FIELD_W = 2;
  localparam int WORD_W  = 32;
  localparam int FIELDS  = 16;
  localparam int IDX_W   = 4;

  typedef logic [FIELD_W-1:0] field_t;
  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [FIELDS-1:0]  fen_t;

  // Index of the field that completes a word.
  localparam idx_t LAST_IDX = 4'd15;

  // Overlay data onto every field slot whose enable bit is set.
  function automatic word_t merge_field(input word_t acc, input fen_t en, input field_t data);
    word_t w;
    w = acc;
    for (int k = 0; k < FIELDS; k++) begin
      w[k*FIELD_W +: FIELD_W] = en[k] ? data : w[k*FIELD_W +: FIELD_W];
    end
    return w;
  endfunction

endpackage

// File: rtl/pack_2_32_if.sv
// pack_2_32_if -- valid/ready handshake bundle for the field packer.
//   in_valid/in_ready/in_data    : 2-bit field stream into the packer
//   out_valid/out_ready/out_data : 32-bit packed word stream out
//   in_flush/out_partial         : present only with PACK_2_32_FLUSH_EN
// Modports: slave = packer side, master = producer/consumer side.
interface pack_2_32_if;
  import pack_2_32_pkg::*;

  logic   in_valid;
  logic   in_ready;
  field_t in_data;
  logic   out_valid;
  logic   out_ready;
  word_t  out_data;
`ifdef PACK_2_32_FLUSH_EN
  logic   in_flush;
  logic   out_partial;

  modport slave  (input  in_valid, in_data, out_ready, in_flush,
                  output in_ready, out_valid, out_data, out_partial);
  modport master (output in_valid, in_data, out_ready, in_flush,
                  input  in_ready, out_valid, out_data, out_partial);
`else
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
`endif

endinterface

// File: rtl/pack_2_32_dec_4_16.sv
// dec_4_16 -- combinational one-hot decoder from field index to field
// write enables.
//   idx : current field position (0..15)
//   en  : one-hot enable, bit idx set
module dec_4_16
  import pack_2_32_pkg::*;
(
  input  idx_t idx,
  output fen_t en
);

  // One-hot decode of the field index.
  always_comb begin
    en      = {FIELDS{1'b0}};
    en[idx] = 1'b1;
  end

endmodule

// File: rtl/pack_2_32.sv
// pack_2_32 -- packs a stream of 2-bit fields into 32-bit words, field 0
// in bits [1:0] and field 15 in bits [31:30]. One output word register
// with valid/ready; a completed word appears on out_data one cycle after
// its 16th field is accepted.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : pack_2_32_if.slave handshake bundle
// Optional macro PACK_2_32_FLUSH_EN adds in_flush/out_partial, which let
// a producer emit a partially filled word (unwritten fields are 0).
module pack_2_32
  import pack_2_32_pkg::*;
(
  input logic        clk,
  input logic        reset_n,
  pack_2_32_if.slave bus
);

  idx_t  idx_r;
  word_t acc_r;
  word_t out_data_r;
  logic  out_valid_r;
`ifdef PACK_2_32_FLUSH_EN
  logic  out_partial_r;
`endif

  fen_t  fen_s;
  logic  in_ready_s;
  logic  accept_s;
  logic  last_s;
  logic  flush_s;
  logic  emit_s;
  word_t merged_s;

  dec_4_16 u_dec (
    .idx (idx_r),
    .en  (fen_s)
  );

  // Handshake decode and the word as it stands after this cycle's field.
  always_comb begin
    in_ready_s = ~out_valid_r | bus.out_ready;
    accept_s   = bus.in_valid & in_ready_s;
    if (accept_s) begin
      merged_s = merge_field(acc_r, fen_s, bus.in_data);
    end else begin
      merged_s = acc_r;
    end
    last_s = accept_s & (idx_r == LAST_IDX);
`ifdef PACK_2_32_FLUSH_EN
    // A flush only counts when it could be accepted and there is something to emit.
    flush_s = bus.in_flush & in_ready_s & ((idx_r != 4'd0) | bus.in_valid);
`else
    flush_s = 1'b0;
`endif
    emit_s = last_s | flush_s;
  end

  // Accumulator, field index and output word register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r         <= 32'h0000_0000;
      idx_r         <= 4'd0;
      out_data_r    <= 32'h0000_0000;
      out_valid_r   <= 1'b0;
`ifdef PACK_2_32_FLUSH_EN
      out_partial_r <= 1'b0;
`endif
    end else if (emit_s) begin
      // emit_s implies in_ready, so any pending word is leaving this cycle.
      out_data_r    <= merged_s;
      out_valid_r   <= 1'b1;
`ifdef PACK_2_32_FLUSH_EN
      out_partial_r <= ~last_s;
`endif
      acc_r         <= 32'h0000_0000;
      idx_r         <= 4'd0;
    end else begin
      if (out_valid_r & bus.out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      if (accept_s) begin
        acc_r <= merged_s;
        idx_r <= idx_r + 4'd1;
      end else begin
        acc_r <= acc_r;
        idx_r <= idx_r;
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_data    = out_data_r;
`ifdef PACK_2_32_FLUSH_EN
  assign bus.out_partial = out_partial_r;
`endif

endmodule
